// File: rtl/tcm_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcm_arbiter_pkg
// Brief    : Shared encodings for the two-port TCM arbiter: femto bus access
//            sizes, per-port state encodings and port identifiers.
// Revision : 1.0 - initial release
// ============================================================================
package tcm_arbiter_pkg;

    // femto bus access sizes
    localparam int BUS_ACC_CNT = 3;
    localparam int BUS_ACC_W   = $clog2(BUS_ACC_CNT);
    localparam logic [BUS_ACC_W-1:0] BUS_ACC_1B = BUS_ACC_W'(0);
    localparam logic [BUS_ACC_W-1:0] BUS_ACC_2B = BUS_ACC_W'(1);
    localparam logic [BUS_ACC_W-1:0] BUS_ACC_4B = BUS_ACC_W'(2);

    // Port identifiers, also used as the owner encoding
    localparam logic TCM_ARB_PORT_I = 1'b0;
    localparam logic TCM_ARB_PORT_D = 1'b1;

    // Per-port request state
    typedef enum logic [1:0] {
        TCM_ARB_IDLE = 2'd0,
        TCM_ARB_PEND = 2'd1,
        TCM_ARB_WAIT = 2'd2
    } tcm_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/tcm_arb_port.sv
`default_nettype none
// ============================================================================
// Module   : tcm_arb_port
// Brief    : One arbiter port: request state machine, pending-request buffer
//            and live/pending field mux feeding the TCM issue path.
// Revision : 1.0 - initial release
// ============================================================================
module tcm_arb_port
    import tcm_arbiter_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_req,
    input  logic [BYTE_ADDR_WIDTH-1:0] i_addr,
    input  logic                       i_wr_b,
    input  logic [BUS_ACC_W-1:0]       i_acc,
    input  logic [31:0]                i_wdata,
    input  logic                       i_grant,
    input  logic                       i_done,
    output logic                       o_cand,
    output logic                       o_pend,
    output logic                       o_viol,
    output logic [BYTE_ADDR_WIDTH-1:0] o_addr,
    output logic                       o_wr_b,
    output logic [BUS_ACC_W-1:0]       o_acc,
    output logic [31:0]                o_wdata
);

    tcm_arb_state_e               r_state;
    tcm_arb_state_e               w_state_nxt;
    logic [BYTE_ADDR_WIDTH-1:0]   r_pend_addr;
    logic                         r_pend_wr_b;
    logic [BUS_ACC_W-1:0]         r_pend_acc;
    logic [31:0]                  r_pend_wdata;
    logic                         w_free;
    logic                         w_capture;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= TCM_ARB_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and port status; a port finishing its response this cycle
    // may take a new request exactly as if it were idle.
    always_comb begin
        w_state_nxt = r_state;
        w_free      = (r_state == TCM_ARB_IDLE) || ((r_state == TCM_ARB_WAIT) && i_done);
        w_capture   = w_free && i_req && !i_grant;
        o_viol      = i_req && !w_free;
        o_pend      = (r_state == TCM_ARB_PEND);
        o_cand      = (w_free && i_req) || o_pend;
        if (w_free && i_req)
            w_state_nxt = i_grant ? TCM_ARB_WAIT : TCM_ARB_PEND;
        else if (o_pend && i_grant)
            w_state_nxt = TCM_ARB_WAIT;
        else if ((r_state == TCM_ARB_WAIT) && i_done)
            w_state_nxt = TCM_ARB_IDLE;
    end

    // Buffer the fields of a request that lost arbitration
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend_addr  <= '0;
            r_pend_wr_b  <= 1'b0;
            r_pend_acc   <= '0;
            r_pend_wdata <= '0;
        end else if (w_capture) begin
            r_pend_addr  <= i_addr;
            r_pend_wr_b  <= i_wr_b;
            r_pend_acc   <= i_acc;
            r_pend_wdata <= i_wdata;
        end
    end

    assign o_addr  = o_pend ? r_pend_addr  : i_addr;
    assign o_wr_b  = o_pend ? r_pend_wr_b  : i_wr_b;
    assign o_acc   = o_pend ? r_pend_acc   : i_acc;
    assign o_wdata = o_pend ? r_pend_wdata : i_wdata;

endmodule
`default_nettype wire

// File: rtl/tcm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tcm_arbiter
// Brief    : Shares one single-cycle TCM controller between the fetch (I) and
//            data (D) femto strobe buses. Losing requests are buffered, so a
//            master only ever sees extra latency, never backpressure.
// Config   : TCM_ARB_RR_EN - round-robin on a fresh contention; when
//            undefined, D has fixed priority over I. A buffered request
//            always beats a fresh one.
// Revision : 1.0 - initial release
// ============================================================================
module tcm_arbiter
    import tcm_arbiter_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_req,
    output logic                       i_resp,
    input  logic [BYTE_ADDR_WIDTH-1:0] i_addr,
    input  logic                       i_wr_b,
    input  logic [BUS_ACC_W-1:0]       i_acc,
    input  logic [31:0]                i_wdata,
    output logic [31:0]                i_rdata,
    output logic                       i_fault,
    input  logic                       d_req,
    output logic                       d_resp,
    input  logic [BYTE_ADDR_WIDTH-1:0] d_addr,
    input  logic                       d_wr_b,
    input  logic [BUS_ACC_W-1:0]       d_acc,
    input  logic [31:0]                d_wdata,
    output logic [31:0]                d_rdata,
    output logic                       d_fault,
    output logic                       t_req,
    input  logic                       t_resp,
    output logic [BYTE_ADDR_WIDTH-1:0] t_addr,
    output logic                       t_wr_b,
    output logic [BUS_ACC_W-1:0]       t_acc,
    output logic [31:0]                t_wdata,
    input  logic [31:0]                t_rdata,
    input  logic                       t_fault
);

    logic                       w_i_cand, w_i_pend, w_i_viol, w_i_grant, w_i_done;
    logic                       w_d_cand, w_d_pend, w_d_viol, w_d_grant, w_d_done;
    logic [BYTE_ADDR_WIDTH-1:0] w_i_addr, w_d_addr;
    logic                       w_i_wr_b, w_d_wr_b;
    logic [BUS_ACC_W-1:0]       w_i_acc, w_d_acc;
    logic [31:0]                w_i_wdata, w_d_wdata;
    logic                       w_sel;
    logic                       w_tie_winner;
    logic                       r_owner_vld;
    logic                       r_owner;
    logic                       r_proto_err;

    tcm_arb_port #(.BYTE_ADDR_WIDTH(BYTE_ADDR_WIDTH)) u_port_i (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_wr_b(i_wr_b), .i_acc(i_acc), .i_wdata(i_wdata),
        .i_grant(w_i_grant), .i_done(w_i_done),
        .o_cand(w_i_cand), .o_pend(w_i_pend), .o_viol(w_i_viol),
        .o_addr(w_i_addr), .o_wr_b(w_i_wr_b), .o_acc(w_i_acc), .o_wdata(w_i_wdata)
    );

    tcm_arb_port #(.BYTE_ADDR_WIDTH(BYTE_ADDR_WIDTH)) u_port_d (
        .clk(clk), .rstn(rstn),
        .i_req(d_req), .i_addr(d_addr), .i_wr_b(d_wr_b), .i_acc(d_acc), .i_wdata(d_wdata),
        .i_grant(w_d_grant), .i_done(w_d_done),
        .o_cand(w_d_cand), .o_pend(w_d_pend), .o_viol(w_d_viol),
        .o_addr(w_d_addr), .o_wr_b(w_d_wr_b), .o_acc(w_d_acc), .o_wdata(w_d_wdata)
    );

`ifdef TCM_ARB_RR_EN
    logic r_rr_ptr;
    logic w_fresh_tie;

    assign w_fresh_tie  = w_i_cand && w_d_cand && (w_i_pend == w_d_pend);
    assign w_tie_winner = r_rr_ptr;

    // Round-robin pointer names the next fresh-contention winner
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)            r_rr_ptr <= TCM_ARB_PORT_I;
        else if (w_fresh_tie) r_rr_ptr <= ~r_rr_ptr;
    end
`else
    assign w_tie_winner = TCM_ARB_PORT_D;
`endif

    // Winner select: a buffered request beats a fresh one, which bounds the
    // loser's latency to one extra cycle
    always_comb begin
        w_sel = TCM_ARB_PORT_D;
        if (w_i_cand && w_d_cand) begin
            if (w_i_pend != w_d_pend) w_sel = w_i_pend ? TCM_ARB_PORT_I : TCM_ARB_PORT_D;
            else                      w_sel = w_tie_winner;
        end else if (w_i_cand) begin
            w_sel = TCM_ARB_PORT_I;
        end
    end

    assign w_i_grant = w_i_cand && (w_sel == TCM_ARB_PORT_I);
    assign w_d_grant = w_d_cand && (w_sel == TCM_ARB_PORT_D);

    assign t_req   = w_i_cand || w_d_cand;
    assign t_addr  = (w_sel == TCM_ARB_PORT_D) ? w_d_addr  : w_i_addr;
    assign t_wr_b  = (w_sel == TCM_ARB_PORT_D) ? w_d_wr_b  : w_i_wr_b;
    assign t_acc   = (w_sel == TCM_ARB_PORT_D) ? w_d_acc   : w_i_acc;
    assign t_wdata = (w_sel == TCM_ARB_PORT_D) ? w_d_wdata : w_i_wdata;

    // Remember who was issued last cycle so the response can be steered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner_vld <= 1'b0;
            r_owner     <= TCM_ARB_PORT_I;
        end else begin
            r_owner_vld <= t_req;
            r_owner     <= w_sel;
        end
    end

    // Sticky record of a request arriving on a busy port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_proto_err <= 1'b0;
        else       r_proto_err <= r_proto_err || w_i_viol || w_d_viol;
    end

    assign w_i_done = t_resp && r_owner_vld && (r_owner == TCM_ARB_PORT_I);
    assign w_d_done = t_resp && r_owner_vld && (r_owner == TCM_ARB_PORT_D);

    assign i_resp  = w_i_done;
    assign d_resp  = w_d_done;
    assign i_rdata = t_rdata;
    assign d_rdata = t_rdata;
    assign i_fault = t_fault && w_i_done;
    assign d_fault = t_fault && w_d_done;

endmodule
`default_nettype wire
